// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM over a shared memory/ALU datapath,
// with a variable-latency memory handshake, an access timeout, sticky fault
// flags and a retired-instruction counter.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALU_Control,
  output logic [1:0]       PCSrc,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // Wide enough to hold MEM_TIMEOUT-1; at least one bit when disabled.
  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             ill_q, ill_d, merr_q, merr_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             retire, tmo;

  // Next-state, sticky-flag and datapath-control decode for the current state.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    ill_d       = ill_q;
    merr_d      = merr_q;
    retire      = 1'b0;
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Control = 3'b000;
    PCSrc       = 2'b00;
    pc_en       = 1'b0;
    // Last permitted wait cycle with no ready: the access is abandoned.
    tmo = (MEM_TIMEOUT > 0) && !mem_ready && (int'(wait_q) == MEM_TIMEOUT - 1);
    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        ALUSrcB     = 2'b01;
        ALU_Control = ALU_ADD;
        IRWrite     = mem_ready;
        pc_en       = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (tmo) begin state_d = S_FAULT; merr_d = 1'b1; end
        else wait_d = wait_q + 1'b1;
      end
      S_DECODE: begin
        ALUSrcB     = 2'b11;
        ALU_Control = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE: begin
            if (SUPPORT_BNE) state_d = S_BRANCH;
            else begin state_d = S_FAULT; ill_d = 1'b1; end
          end
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin state_d = S_FAULT; ill_d = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_Control = ALU_ADD;
        state_d     = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (tmo) begin state_d = S_FAULT; merr_d = 1'b1; end
        else wait_d = wait_q + 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin retire = 1'b1; state_d = S_FETCH; end
        else if (tmo) begin state_d = S_FAULT; merr_d = 1'b1; end
        else wait_d = wait_q + 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
        case (Funct)
          6'b100000: ALU_Control = ALU_ADD;
          6'b100010: ALU_Control = ALU_SUB;
          6'b100100: ALU_Control = 3'b000;
          6'b100101: ALU_Control = 3'b001;
          6'b101010: ALU_Control = 3'b111;
          default: begin state_d = S_FAULT; ill_d = 1'b1; end
        endcase
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCSrc       = 2'b01;
        pc_en       = (Opcode == OP_BNE) ? ~zero : zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_Control = ALU_ADD;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      // FAULT holds; unused encodings are treated as a fault.
      default: state_d = S_FAULT;
    endcase
    // Reset abandons any access: no strobe may reach the datapath.
    if (!rst) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      pc_en    = 1'b0;
    end
    ret_d = ret_q + CNT_W'(retire);
  end

  // State, wait counter, sticky flags and retire counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
      ret_q   <= ret_d;
    end
  end

  assign state      = state_q;
  assign illegal_op = ill_q;
  assign mem_err    = merr_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: a default instance (a) driven from a per-cycle
// vector table through a scoreboard queue, and a small-parameter instance (b)
// sharing the same inputs for timeout, bne-disabled and counter-wrap cases.
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] Opcode, Funct;

  logic a_mr, a_iord, a_mw, a_irw, a_rd, a_m2r, a_rw, a_sa, a_pce, a_ill, a_merr;
  logic [1:0] a_sb, a_pcs;
  logic [2:0] a_alu;
  logic [3:0] a_st;
  logic [31:0] a_ret;

  logic b_mr, b_iord, b_mw, b_irw, b_rd, b_m2r, b_rw, b_sa, b_pce, b_ill, b_merr;
  logic [1:0] b_sb, b_pcs;
  logic [2:0] b_alu;
  logic [3:0] b_st;
  logic [3:0] b_ret;

  always #5 clk = ~clk;

  mips_mc_ctrl u_a (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_mr), .IorD(a_iord), .MemWrite(a_mw),
    .IRWrite(a_irw), .RegDst(a_rd), .MemtoReg(a_m2r), .RegWrite(a_rw),
    .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALU_Control(a_alu), .PCSrc(a_pcs),
    .pc_en(a_pce), .state(a_st), .illegal_op(a_ill), .mem_err(a_merr),
    .retired(a_ret)
  );

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .SUPPORT_BNE(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(b_mr), .IorD(b_iord), .MemWrite(b_mw),
    .IRWrite(b_irw), .RegDst(b_rd), .MemtoReg(b_m2r), .RegWrite(b_rw),
    .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALU_Control(b_alu), .PCSrc(b_pcs),
    .pc_en(b_pce), .state(b_st), .illegal_op(b_ill), .mem_err(b_merr),
    .retired(b_ret)
  );

  wire [19:0] a_out = {a_st, a_mr, a_iord, a_mw, a_irw, a_rd, a_m2r, a_rw, a_sa,
                       a_sb, a_alu, a_pcs, a_pce};
  wire [4:0]  b_strb = {b_mr, b_mw, b_irw, b_rw, b_pce};

  typedef struct {
    string       nm;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [19:0] exp;
    int unsigned ret;
    logic        ill;
    logic        merr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned ret_e = 0;
  logic ill_e = 1'b0;
  logic merr_e = 1'b0;

  // Expected a-outputs: state, mem_req, IorD, MemWrite, IRWrite, RegDst,
  // MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALU_Control, PCSrc, pc_en.
  function automatic logic [19:0] o(input logic [3:0] st, input logic mr, iord, mw,
      irw, rd, m2r, rw, sa, input logic [1:0] s_b, input logic [2:0] alu,
      input logic [1:0] pcs, input logic pce);
    return {st, mr, iord, mw, irw, rd, m2r, rw, sa, s_b, alu, pcs, pce};
  endfunction

  task automatic row(input string nm, input logic r, input logic [5:0] op, fn,
                     input logic z, rdy, input logic [19:0] e);
    vec_t v;
    v.nm = nm; v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
    v.ret = ret_e; v.ill = ill_e; v.merr = merr_e;
    tbl.push_back(v);
  endtask

  task automatic t_fetch(input logic [5:0] op, fn, input logic z, input int waits);
    for (int i = 0; i < waits; i++)
      row("fetch_wait", 1, op, fn, z, 0, o(0,1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0));
    row("fetch", 1, op, fn, z, 1, o(0,1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1));
    row("decode", 1, op, fn, z, 0, o(1,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0));
  endtask

  task automatic t_r(input logic [5:0] fn, input logic [2:0] alu);
    t_fetch(6'b000000, fn, 0, 0);
    row("exec", 1, 6'b000000, fn, 0, 0, o(6,0,0,0,0,0,0,0,1,2'b00,alu,2'b00,0));
    row("aluwb", 1, 6'b000000, fn, 0, 0, o(7,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0));
    ret_e++;
  endtask

  task automatic t_lw(input int w1, w2);
    t_fetch(6'b100011, 0, 0, w1);
    row("memadr", 1, 6'b100011, 0, 0, 0, o(2,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
    for (int i = 0; i < w2; i++)
      row("memrd_wait", 1, 6'b100011, 0, 0, 0, o(3,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    row("memrd", 1, 6'b100011, 0, 0, 1, o(3,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    row("memwb", 1, 6'b100011, 0, 0, 0, o(4,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0));
    ret_e++;
  endtask

  task automatic t_br(input logic [5:0] op, input logic z, pce);
    t_fetch(op, 0, z, 0);
    row("branch", 1, op, 0, z, 0, o(8,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,pce));
    ret_e++;
  endtask

  task automatic t_reset(input logic [3:0] st);
    row("reset", 0, 0, 0, 0, 1, o(st,0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0));
    ret_e = 0; ill_e = 0; merr_e = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [5:0] op, fn, input logic z, rdy);
    rst = r; Opcode = op; Funct = fn; zero = z; mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hard_reset();
    drv(0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    vec_t v;
    // ---------------- table construction ----------------
    row("rst0", 0, 0, 0, 0, 1, o(0,0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0));
    t_r(6'b100000, 3'b010);
    t_r(6'b100010, 3'b110);
    t_r(6'b100100, 3'b000);
    t_r(6'b100101, 3'b001);
    t_r(6'b101010, 3'b111);
    t_lw(3, 3);
    t_lw(0, 0);
    t_fetch(6'b101011, 0, 0, 0);
    row("memadr_sw", 1, 6'b101011, 0, 0, 0, o(2,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
    row("memwr", 1, 6'b101011, 0, 0, 1, o(5,1,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    ret_e++;
    t_br(6'b000100, 1, 1);
    t_br(6'b000100, 0, 0);
    t_br(6'b000101, 0, 1);
    t_br(6'b000101, 1, 0);
    t_fetch(6'b001000, 0, 0, 0);
    row("addiex", 1, 6'b001000, 0, 0, 0, o(9,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
    row("addiwb", 1, 6'b001000, 0, 0, 0, o(10,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0));
    ret_e++;
    t_fetch(6'b000010, 0, 0, 0);
    row("jump", 1, 6'b000010, 0, 0, 0, o(11,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1));
    ret_e++;
    t_fetch(6'b111111, 0, 0, 0);
    ill_e = 1;
    row("fault_op", 1, 6'b111111, 0, 0, 1, o(15,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    row("fault_hold", 1, 6'b111111, 0, 1, 1, o(15,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    row("rst_fault", 0, 0, 0, 0, 1, o(15,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    ret_e = 0; ill_e = 0; merr_e = 0;
    t_r(6'b100000, 3'b010);
    t_fetch(6'b000000, 6'b000111, 0, 0);
    row("exec_badfn", 1, 0, 6'b000111, 0, 0, o(6,0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0));
    ill_e = 1;
    row("fault_fn", 1, 0, 6'b000111, 0, 1, o(15,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    row("rst_fault2", 0, 0, 0, 0, 1, o(15,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0));
    ret_e = 0; ill_e = 0;
    t_reset(4'd0);

    // ---------------- table application ----------------
    drv(0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy);
      sb.push_back(tbl[i]);
      @(negedge clk);
      v = sb.pop_front();
      chk({v.nm, ".out"}, 32'(a_out), 32'(v.exp));
      chk({v.nm, ".retired"}, a_ret, v.ret);
      chk({v.nm, ".illegal_op"}, 32'(a_ill), 32'(v.ill));
      chk({v.nm, ".mem_err"}, 32'(a_merr), 32'(v.merr));
      tick();
    end

    // ---------------- timeout (b: MEM_TIMEOUT=4) ----------------
    hard_reset();
    drv(1, 0, 6'b100000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo_wait.b_state", 32'(b_st), 0);
      chk("tmo_wait.b_mem_req", 32'(b_mr), 1);
      tick();
    end
    @(negedge clk);
    chk("tmo.b_state", 32'(b_st), 15);
    chk("tmo.b_mem_err", 32'(b_merr), 1);
    chk("tmo.b_strobes", 32'(b_strb), 0);
    chk("tmo.a_state", 32'(a_st), 0);
    chk("tmo.a_mem_req", 32'(a_mr), 1);
    chk("tmo.a_mem_err", 32'(a_merr), 0);
    drv(1, 0, 6'b100000, 0, 1);
    tick();
    @(negedge clk);
    chk("tmo_hold.b_state", 32'(b_st), 15);
    chk("tmo_hold.b_strobes", 32'(b_strb), 0);
    drv(0, 0, 6'b100000, 0, 1);
    @(negedge clk);
    chk("tmo_rst.b_strobes", 32'(b_strb), 0);
    tick();
    drv(1, 0, 6'b100000, 0, 0);
    @(negedge clk);
    chk("tmo_clr.b_state", 32'(b_st), 0);
    chk("tmo_clr.b_mem_err", 32'(b_merr), 0);
    chk("tmo_clr.b_illegal_op", 32'(b_ill), 0);
    // ready on the limit cycle completes the access
    for (int i = 0; i < 3; i++) tick();
    drv(1, 0, 6'b100000, 0, 1);
    @(negedge clk);
    chk("rdy_wins.b_IRWrite", 32'(b_irw), 1);
    tick();
    @(negedge clk);
    chk("rdy_wins.b_state", 32'(b_st), 1);
    chk("rdy_wins.b_mem_err", 32'(b_merr), 0);

    // ---------------- bne illegal when unsupported (b) ----------------
    hard_reset();
    drv(1, 6'b000101, 0, 0, 1);
    tick(); tick();
    @(negedge clk);
    chk("bne_off.b_state", 32'(b_st), 15);
    chk("bne_off.b_illegal_op", 32'(b_ill), 1);
    chk("bne_off.b_retired", 32'(b_ret), 0);
    chk("bne_on.a_state", 32'(a_st), 8);
    chk("bne_on.a_illegal_op", 32'(a_ill), 0);

    // ---------------- 17 jumps: 4-bit counter wraps ----------------
    hard_reset();
    drv(1, 6'b000010, 0, 0, 1);
    for (int i = 0; i < 51; i++) tick();
    @(negedge clk);
    chk("j17.b_retired", 32'(b_ret), 1);
    chk("j17.a_retired", a_ret, 17);
    chk("j17.b_state", 32'(b_st), 0);

    // ---------------- reset in MEMWR ----------------
    hard_reset();
    drv(1, 6'b101011, 0, 0, 1);
    tick(); tick();
    drv(1, 6'b101011, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("memwr.a_state", 32'(a_st), 5);
    chk("memwr.a_MemWrite", 32'(a_mw), 1);
    drv(0, 6'b101011, 0, 0, 0);
    @(negedge clk);
    chk("memwr_rst.a_MemWrite", 32'(a_mw), 0);
    chk("memwr_rst.a_mem_req", 32'(a_mr), 0);
    chk("memwr_rst.b_MemWrite", 32'(b_mw), 0);
    tick();
    drv(1, 6'b101011, 0, 0, 0);
    @(negedge clk);
    chk("memwr_after.a_state", 32'(a_st), 0);
    chk("memwr_after.a_retired", a_ret, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute, memory and writeback over several cycles, sharing one memory and one ALU.
- Adds a variable-latency memory handshake with a timeout, optional bne support, sticky fault reporting and a retired-instruction counter.
- Sits beside the multicycle datapath, takes Opcode/Funct from its instruction register, and drives all datapath strobes and muxes.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready per access; 0 disables the timeout.
- SUPPORT_BNE, 1, 1 = opcode 000101 (bne) legal; 0 = bne is an illegal opcode.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- Opcode  in  6  Instr[31:26] from the instruction register.
- Funct  in  6  Instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemWrite  out  1  write strobe, valid with mem_req.
- IRWrite  out  1  load the instruction register.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = data register, 0 = ALUOut.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2.
- ALU_Control  out  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- state  out  4  current state, for debug.
- illegal_op  out  1  sticky: an illegal opcode or funct was decoded.
- mem_err  out  1  sticky: the memory access timed out.
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset:
  - On a clk edge with rst=0: state=FETCH(0), wait counter=0, illegal_op=0, mem_err=0, retired=0.
  - While rst=0, every strobe (mem_req, MemWrite, IRWrite, RegWrite, pc_en) is forced to 0.
  - Reset mid-access abandons the access; no stray writes occur.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, FAULT 15.
- Unlisted outputs in any state are 0.
- FETCH:
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
  - IRWrite=pc_en=mem_ready, so both strobe exactly once, on the ready cycle.
  - Advances to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by Opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq), or 000101 (bne) when SUPPORT_BNE=1 -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other opcode -> FAULT with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1. On mem_ready -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Retires; -> FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1. On mem_ready it retires -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALU_Control by Funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other Funct -> FAULT with illegal_op=1 instead of ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Retires; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. pc_en=zero for beq, ~zero for bne. Retires; -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Retires; -> FETCH.
- JUMP: PCSrc=10, pc_en=1. Retires; -> FETCH.
- Memory timeout:
  - The wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle there with mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT with mem_err=1.
  - mem_ready on the same cycle the limit is reached wins: the access completes normally.
- FAULT: all strobes 0. Held until reset; illegal_op and mem_err stay set until reset.
- retired: increments by 1 on the retiring cycle only, wraps from all-ones to 0. Faulting instructions do not count.
- A zero-wait access, with mem_ready=1 in the first cycle, costs 1 cycle.
- Instruction latencies with zero-wait memory:
  - lw 5, sw 4, R-type 4, addi 4, branch 3, j 3.

Test Plan:
- Reset, mem_ready=1, Opcode=000000/Funct=100000 -> states 0,1,6,7,0; ALU_Control=010 in EXEC; RegWrite=1 only in ALUWB; retired=1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEMRD -> mem_req held; IRWrite and pc_en exactly one cycle each; latency 11; RegWrite in MEMWB.
- beq with zero=1, then zero=0; bne with zero=0 (SUPPORT_BNE=1) -> pc_en 1, 0, 1 in BRANCH; PCSrc=01.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 cycles, mem_err=1, all strobes 0; rst=0 for one edge clears to FETCH with flags 0.
- Opcode=111111; separately R-type Funct=000111; separately bne with SUPPORT_BNE=0 -> FAULT, illegal_op=1, retired unchanged.
- CNT_W=4, 17 j instructions -> retired = 1; rst=0 asserted in MEMWR -> MemWrite=0 that cycle, state=0 next.
